// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prbs_pkg
// Description : Shared PRBS9 definitions (x^9 + x^5 + 1). Used by both the
//               transmit generator and the receive checker, so the tap
//               positions, register width and checker state encoding are
//               defined in one place.
// Revision    : 1.0 - initial release
// ============================================================================
package prbs_pkg;

    // PRBS9 register width and feedback taps (bit indices into the LFSR).
    localparam int C_PRBS_LEN   = 9;
    localparam int C_PRBS_TAP_A = 8;
    localparam int C_PRBS_TAP_B = 4;

    // Checker state encoding.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs_state_e;

    // Next PRBS9 bit predicted from the current register contents.
    function automatic logic prbs9_bit(input logic [C_PRBS_LEN-1:0] lfsr);
        return lfsr[C_PRBS_TAP_A] ^ lfsr[C_PRBS_TAP_B];
    endfunction

    // Shift a new bit into position 0; the oldest bit falls out of the top.
    function automatic logic [C_PRBS_LEN-1:0] prbs9_shift(
        input logic [C_PRBS_LEN-1:0] lfsr,
        input logic                  b
    );
        return {lfsr[C_PRBS_LEN-2:0], b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_rx_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : prbs_rx_checker_if
// Description : Sample/status bundle between the receive datapath (master)
//               and the PRBS checker (slave).
//   i_valid     : sample strobe
//   i_enable    : low freezes the checker
//   i_clear     : synchronous clear of both counters
//   i_data      : signed filtered sample, NB_DATA bits
//   o_lock      : checker is LOCKED
//   o_err       : one-cycle pulse per error seen while LOCKED
//   o_bit_count : samples checked while LOCKED (saturating)
//   o_err_count : errors counted while LOCKED (saturating)
//   o_leds      : {lock, error-in-window, state[1:0]}
// Revision    : 1.0 - initial release
// ============================================================================
interface prbs_rx_checker_if #(
    parameter int NB_DATA = 13,
    parameter int NB_CNT  = 32
);
    logic               i_valid;
    logic               i_enable;
    logic               i_clear;
    logic [NB_DATA-1:0] i_data;
    logic               o_lock;
    logic               o_err;
    logic [NB_CNT-1:0]  o_bit_count;
    logic [NB_CNT-1:0]  o_err_count;
    logic [3:0]         o_leds;

    modport master (
        output i_valid, i_enable, i_clear, i_data,
        input  o_lock, o_err, o_bit_count, o_err_count, o_leds
    );

    modport slave (
        input  i_valid, i_enable, i_clear, i_data,
        output o_lock, o_err, o_bit_count, o_err_count, o_leds
    );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones. Clear wins over an
//               increment on the same edge.
//   clock     : rising-edge clock
//   i_reset_n : asynchronous active-low reset
//   i_clear   : synchronous clear
//   i_inc     : increment request
//   o_count   : current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clock,
    input  wire logic             i_reset_n,
    input  wire logic             i_clear,
    input  wire logic             i_inc,
    output logic      [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/prbs_rx_checker.sv
`default_nettype none
// ============================================================================
// Module      : prbs_rx_checker
// Description : PRBS9 receive checker. Slices the sign of each accepted
//               sample, self-synchronises a local PRBS9 register (SEARCH
//               fills it, VERIFY confirms LOCK_THR predictions), then free-runs
//               in LOCKED and counts bits/errors. ERR_THR errors inside one
//               WIN-sample window drop back to SEARCH.
//   clock     : rising-edge clock
//   i_reset_n : asynchronous active-low reset
//   bus       : sample inputs and status outputs (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_rx_checker
    import prbs_pkg::*;
#(
    parameter int NB_DATA  = 13,
    parameter int NB_CNT   = 32,
    parameter int LOCK_THR = 16,
    parameter int WIN      = 64,
    parameter int ERR_THR  = 8
) (
    input  wire logic       clock,
    input  wire logic       i_reset_n,
    prbs_rx_checker_if.slave bus
);

    localparam int C_FILL_W = 4;
    localparam int C_GOOD_W = (LOCK_THR > 1) ? $clog2(LOCK_THR) : 1;
    localparam int C_WIN_W  = (WIN > 1)      ? $clog2(WIN)      : 1;
    localparam int C_ERR_W  = (ERR_THR > 1)  ? $clog2(ERR_THR)  : 1;

    localparam logic [C_FILL_W-1:0] C_FILL_LAST = C_FILL_W'(C_PRBS_LEN - 1);
    localparam logic [C_GOOD_W-1:0] C_GOOD_LAST = C_GOOD_W'(LOCK_THR - 1);
    localparam logic [C_WIN_W-1:0]  C_WIN_LAST  = C_WIN_W'(WIN - 1);
    localparam logic [C_ERR_W-1:0]  C_ERR_LAST  = C_ERR_W'(ERR_THR - 1);

    prbs_state_e             state_q,   state_d;
    logic [C_PRBS_LEN-1:0]   lfsr_q,    lfsr_d;
    logic [C_FILL_W-1:0]     fill_q,    fill_d;
    logic [C_GOOD_W-1:0]     good_q,    good_d;
    logic [C_WIN_W-1:0]      win_cnt_q, win_cnt_d;
    logic [C_ERR_W-1:0]      win_err_q, win_err_d;
    logic                    led_err_q, led_err_d;
    logic                    err_q,     err_d;

    logic                    w_accept;
    logic                    w_bit;
    logic                    w_pred;
    logic                    w_match;
    logic                    w_win_wrap;
    logic                    w_clear;
    logic                    w_bit_inc;
    logic                    w_err_inc;
    logic                    w_unused_data;
    logic [NB_CNT-1:0]       w_bit_count;
    logic [NB_CNT-1:0]       w_err_count;

    assign w_accept      = bus.i_enable & bus.i_valid;
    // Sign slicer: a non-negative sample is a 1.
    assign w_bit         = ~bus.i_data[NB_DATA-1];
    assign w_pred        = prbs9_bit(lfsr_q);
    assign w_match       = (w_bit == w_pred);
    assign w_win_wrap    = (win_cnt_q == C_WIN_LAST);
    // A disabled checker holds everything, the counters included.
    assign w_clear       = bus.i_enable & bus.i_clear;
    assign w_unused_data = ^bus.i_data[NB_DATA-2:0];

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        fill_d    = fill_q;
        good_d    = good_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        led_err_d = led_err_q;
        err_d     = 1'b0;
        w_bit_inc = 1'b0;
        w_err_inc = 1'b0;

        if (w_accept) begin
            case (state_q)
                SEARCH: begin
                    lfsr_d = prbs9_shift(lfsr_q, w_bit);
                    if (fill_q == C_FILL_LAST) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        good_d  = '0;
                    end else begin
                        fill_d = fill_q + C_FILL_W'(1);
                    end
                end

                VERIFY: begin
                    lfsr_d = prbs9_shift(lfsr_q, w_bit);
                    if (!w_match) begin
                        state_d = SEARCH;
                        fill_d  = '0;
                    end else if (good_q == C_GOOD_LAST) begin
                        state_d   = LOCKED;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        good_d = good_q + C_GOOD_W'(1);
                    end
                end

                LOCKED: begin
                    // Free-run on the prediction; received bits are only compared.
                    lfsr_d    = prbs9_shift(lfsr_q, w_pred);
                    w_bit_inc = 1'b1;
                    win_cnt_d = w_win_wrap ? '0 : (win_cnt_q + C_WIN_W'(1));
                    if (!w_match) begin
                        w_err_inc = 1'b1;
                        err_d     = 1'b1;
                        led_err_d = 1'b1;
                    end
                    // The wrapping sample is the last one of the closing window:
                    // it is tested against the threshold before the count clears.
                    if (!w_match && (win_err_q == C_ERR_LAST)) begin
                        state_d = SEARCH;
                        fill_d  = '0;
                    end else if (w_win_wrap) begin
                        win_err_d = '0;
                        if (w_match) begin
                            led_err_d = 1'b0;
                        end
                    end else if (!w_match) begin
                        win_err_d = win_err_q + C_ERR_W'(1);
                    end
                end

                default: begin
                    state_d = SEARCH;
                    fill_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= SEARCH;
            lfsr_q    <= '0;
            fill_q    <= '0;
            good_q    <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            led_err_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            fill_q    <= fill_d;
            good_q    <= good_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            led_err_q <= led_err_d;
            err_q     <= err_d;
        end
    end

    sat_counter #(.WIDTH(NB_CNT)) u_bit_cnt (
        .clock     (clock),
        .i_reset_n (i_reset_n),
        .i_clear   (w_clear),
        .i_inc     (w_bit_inc),
        .o_count   (w_bit_count)
    );

    sat_counter #(.WIDTH(NB_CNT)) u_err_cnt (
        .clock     (clock),
        .i_reset_n (i_reset_n),
        .i_clear   (w_clear),
        .i_inc     (w_err_inc),
        .o_count   (w_err_count)
    );

    assign bus.o_lock      = (state_q == LOCKED);
    assign bus.o_err       = err_q;
    assign bus.o_bit_count = w_bit_count;
    assign bus.o_err_count = w_err_count;
    assign bus.o_leds      = {(state_q == LOCKED), led_err_q, state_q};

endmodule
`default_nettype wire

// File: tb/tb_prbs_rx_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_prbs_rx_checker
// Description : Directed bench for prbs_rx_checker. A local PRBS9 generator
//               (seed 9'h1FF) drives +/-1000 samples, one every 8 cycles;
//               single samples are inverted to create errors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs_rx_checker;

    localparam int NB_DATA = 13;
    localparam int NB_CNT  = 4;

    logic       clock     = 1'b0;
    logic       i_reset_n = 1'b0;
    logic [8:0] tx_lfsr   = 9'h1FF;
    int         errors    = 0;
    int         checks    = 0;

    prbs_rx_checker_if #(.NB_DATA(NB_DATA), .NB_CNT(NB_CNT)) bus ();

    prbs_rx_checker #(
        .NB_DATA  (NB_DATA),
        .NB_CNT   (NB_CNT),
        .LOCK_THR (16),
        .WIN      (64),
        .ERR_THR  (8)
    ) dut (
        .clock     (clock),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Idle 7 cycles, then present the next PRBS bit (optionally inverted,
    // optionally with i_clear) for exactly one accepting edge. Returns 1 ns
    // after that edge so callers can sample the registered outputs.
    task automatic send_sample(input bit flip, input bit clr);
        logic b;
        repeat (7) @(posedge clock);
        #1;
        b = tx_lfsr[8] ^ tx_lfsr[4];
        tx_lfsr = {tx_lfsr[7:0], b};
        bus.i_data  = (b ^ flip) ? 13'd1000 : -13'd1000;
        bus.i_valid = 1'b1;
        bus.i_clear = clr;
        @(posedge clock);
        #1;
        bus.i_valid = 1'b0;
        bus.i_clear = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_valid  = 1'b0;
        bus.i_enable = 1'b1;
        bus.i_clear  = 1'b0;
        bus.i_data   = '0;
        i_reset_n    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.o_lock !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b want 0", bus.o_lock); end
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.o_err); end
        checks++; if (bus.o_bit_count !== 4'd0) begin errors++; $display("FAIL reset_bitcnt: got %0d want 0", bus.o_bit_count); end
        checks++; if (bus.o_err_count !== 4'd0) begin errors++; $display("FAIL reset_errcnt: got %0d want 0", bus.o_err_count); end
        checks++; if (bus.o_leds !== 4'b0000) begin errors++; $display("FAIL reset_leds: got %b want 0000", bus.o_leds); end
        i_reset_n = 1'b1;
    endtask

    task automatic test_lock();
        for (int n = 1; n <= 25; n++) begin
            send_sample(1'b0, 1'b0);
            checks++;
            if (bus.o_lock !== ((n == 25) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL lock_at_%0d: got %b want %b", n, bus.o_lock, (n == 25));
            end
            if (n == 9) begin
                checks++; if (bus.o_leds[1:0] !== 2'b01) begin errors++; $display("FAIL verify_state: got %b want 01", bus.o_leds[1:0]); end
            end
        end
        checks++; if (bus.o_err_count !== 4'd0) begin errors++; $display("FAIL lock_errcnt: got %0d want 0", bus.o_err_count); end
        checks++; if (bus.o_bit_count !== 4'd0) begin errors++; $display("FAIL lock_bitcnt: got %0d want 0", bus.o_bit_count); end
        checks++; if (bus.o_leds !== 4'b1010) begin errors++; $display("FAIL lock_leds: got %b want 1010", bus.o_leds); end
    endtask

    task automatic test_single_error();
        repeat (3) send_sample(1'b0, 1'b0);
        send_sample(1'b1, 1'b0);
        checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b want 1", bus.o_err); end
        checks++; if (bus.o_err_count !== 4'd1) begin errors++; $display("FAIL err_count1: got %0d want 1", bus.o_err_count); end
        checks++; if (bus.o_bit_count !== 4'd4) begin errors++; $display("FAIL bitcnt4: got %0d want 4", bus.o_bit_count); end
        checks++; if (bus.o_lock !== 1'b1) begin errors++; $display("FAIL lock_after_err: got %b want 1", bus.o_lock); end
        checks++; if (bus.o_leds[2] !== 1'b1) begin errors++; $display("FAIL led_err_set: got %b want 1", bus.o_leds[2]); end
        @(posedge clock);
        #1;
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL err_pulse_end: got %b want 0", bus.o_err); end
        repeat (2) send_sample(1'b0, 1'b0);
        checks++; if (bus.o_bit_count !== 4'd6) begin errors++; $display("FAIL bitcnt6: got %0d want 6", bus.o_bit_count); end
        checks++; if (bus.o_err_count !== 4'd1) begin errors++; $display("FAIL err_count_hold: got %0d want 1", bus.o_err_count); end
    endtask

    // 6 samples of the first window are used; 58 more reach the wrap.
    task automatic test_window_wrap();
        repeat (57) send_sample(1'b0, 1'b0);
        checks++; if (bus.o_leds[2] !== 1'b1) begin errors++; $display("FAIL led_err_prewrap: got %b want 1", bus.o_leds[2]); end
        checks++; if (bus.o_bit_count !== 4'd15) begin errors++; $display("FAIL bitcnt_sat: got %0d want 15", bus.o_bit_count); end
        send_sample(1'b0, 1'b0);
        checks++; if (bus.o_leds[2] !== 1'b0) begin errors++; $display("FAIL led_err_wrap: got %b want 0", bus.o_leds[2]); end
        checks++; if (bus.o_lock !== 1'b1) begin errors++; $display("FAIL lock_wrap: got %b want 1", bus.o_lock); end
    endtask

    task automatic test_clear_with_valid();
        send_sample(1'b0, 1'b1);
        checks++; if (bus.o_bit_count !== 4'd0) begin errors++; $display("FAIL clear_bitcnt: got %0d want 0", bus.o_bit_count); end
        checks++; if (bus.o_err_count !== 4'd0) begin errors++; $display("FAIL clear_errcnt: got %0d want 0", bus.o_err_count); end
        checks++; if (bus.o_lock !== 1'b1) begin errors++; $display("FAIL clear_lock: got %b want 1", bus.o_lock); end
    endtask

    task automatic test_loss_of_lock();
        for (int k = 1; k <= 8; k++) begin
            send_sample(1'b1, 1'b0);
            checks++; if (bus.o_err_count !== 4'(k)) begin errors++; $display("FAIL loss_errcnt_%0d: got %0d want %0d", k, bus.o_err_count, k); end
            checks++;
            if (bus.o_lock !== ((k == 8) ? 1'b0 : 1'b1)) begin
                errors++; $display("FAIL loss_lock_%0d: got %b want %b", k, bus.o_lock, (k != 8));
            end
            if (k < 8) send_sample(1'b0, 1'b0);
        end
        checks++; if (bus.o_leds[1:0] !== 2'b00) begin errors++; $display("FAIL loss_state: got %b want 00", bus.o_leds[1:0]); end
        checks++; if (bus.o_bit_count !== 4'd15) begin errors++; $display("FAIL loss_bitcnt: got %0d want 15", bus.o_bit_count); end
        for (int n = 1; n <= 25; n++) begin
            send_sample(1'b0, 1'b0);
            if (n >= 24) begin
                checks++;
                if (bus.o_lock !== ((n == 25) ? 1'b1 : 1'b0)) begin
                    errors++; $display("FAIL relock_at_%0d: got %b want %b", n, bus.o_lock, (n == 25));
                end
            end
        end
        checks++; if (bus.o_err_count !== 4'd8) begin errors++; $display("FAIL relock_errcnt: got %0d want 8", bus.o_err_count); end
    endtask

    task automatic test_enable_hold();
        bus.i_clear = 1'b1;
        @(posedge clock);
        #1;
        bus.i_clear  = 1'b0;
        bus.i_enable = 1'b0;
        for (int c = 0; c < 100; c++) begin
            bus.i_valid = ~bus.i_valid;
            bus.i_data  = 13'($urandom);
            @(posedge clock);
            #1;
        end
        bus.i_valid = 1'b0;
        checks++; if (bus.o_lock !== 1'b1) begin errors++; $display("FAIL hold_lock: got %b want 1", bus.o_lock); end
        checks++; if (bus.o_bit_count !== 4'd0) begin errors++; $display("FAIL hold_bitcnt: got %0d want 0", bus.o_bit_count); end
        checks++; if (bus.o_err_count !== 4'd0) begin errors++; $display("FAIL hold_errcnt: got %0d want 0", bus.o_err_count); end
        checks++; if (bus.o_leds[1:0] !== 2'b10) begin errors++; $display("FAIL hold_state: got %b want 10", bus.o_leds[1:0]); end
        bus.i_enable = 1'b1;
        repeat (5) send_sample(1'b0, 1'b0);
        checks++; if (bus.o_bit_count !== 4'd5) begin errors++; $display("FAIL resume_bitcnt: got %0d want 5", bus.o_bit_count); end
        checks++; if (bus.o_err_count !== 4'd0) begin errors++; $display("FAIL resume_errcnt: got %0d want 0", bus.o_err_count); end
    endtask

    task automatic test_async_reset();
        send_sample(1'b1, 1'b0);
        checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL pre_reset_err: got %b want 1", bus.o_err); end
        #2;
        i_reset_n = 1'b0;
        #1;
        checks++; if (bus.o_lock !== 1'b0) begin errors++; $display("FAIL areset_lock: got %b want 0", bus.o_lock); end
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL areset_err: got %b want 0", bus.o_err); end
        checks++; if (bus.o_bit_count !== 4'd0) begin errors++; $display("FAIL areset_bitcnt: got %0d want 0", bus.o_bit_count); end
        checks++; if (bus.o_err_count !== 4'd0) begin errors++; $display("FAIL areset_errcnt: got %0d want 0", bus.o_err_count); end
        checks++; if (bus.o_leds !== 4'b0000) begin errors++; $display("FAIL areset_leds: got %b want 0000", bus.o_leds); end
        @(posedge clock);
        #1;
        i_reset_n = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            send_sample(1'b0, 1'b0);
            if (n >= 24) begin
                checks++;
                if (bus.o_lock !== ((n == 25) ? 1'b1 : 1'b0)) begin
                    errors++; $display("FAIL post_reset_lock_%0d: got %b want %b", n, bus.o_lock, (n == 25));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_window_wrap();
        test_clear_with_valid();
        test_loss_of_lock();
        test_enable_hold();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prbs_rx_checker.md
PRBS_RX_CHECKER -- requirements
Module: prbs_rx_checker

Interface
REQ-001 Parameter NB_DATA, default 13: width of the received filtered sample.
REQ-002 Parameter NB_CNT, default 32: width of the bit and error counters.
REQ-003 Parameter LOCK_THR, default 16: number of consecutive correct predictions required to declare lock.
REQ-004 Parameter WIN, default 64: length of the loss-of-lock window, in valid samples.
REQ-005 Parameter ERR_THR, default 8: number of errors within one window that forces loss of lock.
REQ-006 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-007 Port i_reset_n, input, 1: reset, asynchronous and active-low.
REQ-008 Port i_valid, input, 1: sample strobe from the transmit-side rate counter.
REQ-009 Port i_enable, input, 1: when low, all internal state is held.
REQ-010 Port i_clear, input, 1: synchronous clear of both counters.
REQ-011 Port i_data, input, NB_DATA: received FIR output, signed two's complement.
REQ-012 Port o_lock, output, 1: high while the FSM is in LOCKED.
REQ-013 Port o_err, output, 1: one-cycle pulse on each error detected in LOCKED.
REQ-014 Port o_bit_count, output, NB_CNT: number of valid samples checked while LOCKED.
REQ-015 Port o_err_count, output, NB_CNT: number of errors counted while LOCKED.
REQ-016 Port o_leds, output, 4: {o_lock, o_err held for one window, state[1:0]}.

Function
REQ-017 A sample is accepted only on a clock edge where i_enable and i_valid are both high; the sliced bit is d = ~i_data[NB_DATA-1], so a non-negative sample gives 1.
REQ-018 The local reference is PRBS9, x^9+x^5+1; the predicted bit is p = lfsr[8]^lfsr[4], and p is shifted into lfsr[0].
REQ-019 The FSM has three states: SEARCH, VERIFY and LOCKED; the reset state is SEARCH.
REQ-020 SEARCH: d is shifted into lfsr on each accepted sample; after the 9th accepted sample the FSM moves to VERIFY with good_cnt=0.
REQ-021 VERIFY: if d==p, good_cnt increments; when good_cnt reaches LOCK_THR the FSM moves to LOCKED; on d!=p the FSM moves to SEARCH and the fill count restarts at 0.
REQ-022 LOCKED: lfsr free-runs on p (d is never loaded); each accepted sample increments o_bit_count; d!=p increments o_err_count and the window error count, and pulses o_err in the following cycle.
REQ-023 The window counter counts accepted samples in LOCKED and wraps at WIN, clearing the window error count on wrap.
REQ-024 When the window error count reaches ERR_THR the FSM moves to SEARCH; o_lock falls on the same edge; the counters hold their values.
REQ-025 Counters saturate at all-ones and never wrap.
REQ-026 i_clear zeroes both counters and has priority over a simultaneous increment; the FSM is unaffected.
REQ-027 All outputs are registered; o_lock rises on the edge that accepts the LOCK_THR-th good sample.

Reset
REQ-028 When i_reset_n is low, immediately: state=SEARCH, lfsr=0, and all counters, o_lock, o_err and o_leds are 0, including during LOCKED.
REQ-029 After reset release, the first accepted sample is treated as fill bit 1 of SEARCH.

Structure
REQ-030 The PRBS9 tap positions, the lfsr width (9) and the state encoding (SEARCH=0, VERIFY=1, LOCKED=2) are defined in the shared package prbs_pkg, which the transmit PRBS also uses.
REQ-031 The two saturating counters with clear are implemented in one sub-module, sat_counter, instantiated twice.

Verification
REQ-032 Bench: drive PRBS9 from seed 9'h1FF as samples of +1000/-1000, with i_valid every 8 cycles -> o_lock rises at the 25th accepted sample and o_err_count stays 0.
REQ-033 Bench: after lock, invert one sample -> o_err pulses once, o_err_count=1, o_lock stays high, and o_bit_count continues incrementing.
REQ-034 Bench: inject 8 errors within 64 samples -> o_lock falls at the 8th error, then relocks 25 clean samples later, and o_err_count=8 is retained.
REQ-035 Bench: with NB_CNT=4, stay locked for 20 samples -> o_bit_count holds at 15; asserting i_clear together with a valid sample -> 0.
REQ-036 Bench: assert i_reset_n low mid-LOCKED -> all outputs are 0 immediately, without waiting for a clock edge.
REQ-037 Bench: hold i_enable low for 100 cycles with i_valid toggling -> state, lfsr and counters are unchanged.
